instr_sequencer: RTL and testbench

Instruction sequencer for the microprocessor core. It steps each instruction through fetch, decode, execute and PC-update phases, and drives the program counter's `enable` / `jump` / `jump_address` inputs. It also drives the IR-load and execute strobes for the datapath. It sits between the instruction ROM, the PC and the ALU/register datapath, and is the only block that advances the PC.

---
 rtl/instr_sequencer_if.sv | 52 +++++
 rtl/instr_sequencer.sv | 153 +++++++++++++++
 tb/tb_instr_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Sequencer bus: ROM/datapath status in, PC/datapath control out.
// The step signal exists only when SEQ_SINGLE_STEP_EN is defined.
interface instr_sequencer_if;
    logic        run;
    logic [15:0] instr;
    logic        mem_ready;
    logic        zero_flag;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step;
`endif
    logic        pc_enable;
    logic        pc_jump;
    logic [9:0]  pc_jump_address;
    logic        ir_load;
    logic        exec_en;
    logic        halted;
    logic [15:0] instr_count;

    modport master (
        input  run,
        input  instr,
        input  mem_ready,
        input  zero_flag,
`ifdef SEQ_SINGLE_STEP_EN
        input  step,
`endif
        output pc_enable,
        output pc_jump,
        output pc_jump_address,
        output ir_load,
        output exec_en,
        output halted,
        output instr_count
    );

    modport slave (
        output run,
        output instr,
        output mem_ready,
        output zero_flag,
`ifdef SEQ_SINGLE_STEP_EN
        output step,
`endif
        input  pc_enable,
        input  pc_jump,
        input  pc_jump_address,
        input  ir_load,
        input  exec_en,
        input  halted,
        input  instr_count
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: FETCH/DECODE/EXECUTE/UPDATE stepping with registered PC/datapath strobes.
// Optional single-step PAUSE state enabled by defining SEQ_SINGLE_STEP_EN.
module instr_sequencer #(
    parameter int unsigned         OPCODE_W = 4,
    parameter logic [OPCODE_W-1:0] JMP_OP   = 4'hA,
    parameter logic [OPCODE_W-1:0] BRZ_OP   = 4'hB,
    parameter logic [OPCODE_W-1:0] HALT_OP  = 4'hF
) (
    input logic               clk,
    input logic               reset_n,
    instr_sequencer_if.master bus
);

`ifdef SEQ_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExecute, StUpdate, StHalt, StPause
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExecute, StUpdate, StHalt
    } state_e;
`endif

    state_e state_q, state_d;

    logic [15:0]         ir_q, ir_d;
    logic [OPCODE_W-1:0] opcode;
    logic                pc_enable_q, pc_enable_d;
    logic                pc_jump_q, pc_jump_d;
    logic [9:0]          jump_addr_q, jump_addr_d;
    logic                ir_load_q, ir_load_d;
    logic                exec_en_q, exec_en_d;
    logic                halted_q, halted_d;
    logic [15:0]         count_q, count_d;

    assign opcode = ir_q[15 -: OPCODE_W];

    // IR bits between the opcode and the target address carry no meaning here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q[11:10];

`ifdef SEQ_SINGLE_STEP_EN
    logic step_q;
    logic step_rise;
    assign step_rise = bus.step & ~step_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= bus.step;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        pc_jump_d   = pc_jump_q;
        jump_addr_d = jump_addr_q;
        count_d     = count_q;
        // Strobes are a registered image of the phase, so each is one clean flop output.
        pc_enable_d = (state_q == StUpdate);
        ir_load_d   = (state_q == StDecode);
        exec_en_d   = (state_q == StExecute);
        halted_d    = (state_q == StHalt);

        unique case (state_q)
            StIdle: begin
                if (bus.run) state_d = StFetch;
            end
            StFetch: begin
                if (bus.mem_ready) begin
                    ir_d    = bus.instr;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (opcode == HALT_OP) begin
                    state_d = StHalt;
                end else begin
                    state_d     = StExecute;
                    pc_jump_d   = 1'b0;
                    jump_addr_d = '0;
                    if (opcode == JMP_OP) begin
                        pc_jump_d   = 1'b1;
                        jump_addr_d = ir_q[9:0];
                    end else if (opcode == BRZ_OP) begin
                        pc_jump_d   = bus.zero_flag;
                        jump_addr_d = ir_q[9:0];
                    end
                end
            end
            StExecute: begin
                state_d = StUpdate;
            end
            StUpdate: begin
                if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
`ifdef SEQ_SINGLE_STEP_EN
                state_d = bus.run ? StPause : StIdle;
`else
                state_d = bus.run ? StFetch : StIdle;
`endif
            end
            StHalt: begin
                state_d = StHalt;
            end
`ifdef SEQ_SINGLE_STEP_EN
            StPause: begin
                if (!bus.run) begin
                    state_d = StIdle;
                end else if (step_rise) begin
                    state_d = StFetch;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ir_q        <= '0;
            pc_enable_q <= 1'b0;
            pc_jump_q   <= 1'b0;
            jump_addr_q <= '0;
            ir_load_q   <= 1'b0;
            exec_en_q   <= 1'b0;
            halted_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            pc_enable_q <= pc_enable_d;
            pc_jump_q   <= pc_jump_d;
            jump_addr_q <= jump_addr_d;
            ir_load_q   <= ir_load_d;
            exec_en_q   <= exec_en_d;
            halted_q    <= halted_d;
            count_q     <= count_d;
        end
    end

    assign bus.pc_enable       = pc_enable_q;
    assign bus.pc_jump         = pc_jump_q;
    assign bus.pc_jump_address = jump_addr_q;
    assign bus.ir_load         = ir_load_q;
    assign bus.exec_en         = exec_en_q;
    assign bus.halted          = halted_q;
    assign bus.instr_count     = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus random instruction streams
// checked against a per-instruction timing/jump model.
module tb_instr_sequencer;
    logic clk = 1'b0;
    logic reset_n;

    instr_sequencer_if bus ();

    instr_sequencer #(
        .OPCODE_W(4),
        .JMP_OP  (4'hA),
        .BRZ_OP  (4'hB),
        .HALT_OP (4'hF)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: jump outputs of the last retired instruction and the retired count.
    logic       exp_jump = 1'b0;
    logic [9:0] exp_addr = 10'h000;
    int         retired  = 0;

    logic [30:0] all_outs;
    assign all_outs = {bus.pc_enable, bus.pc_jump, bus.pc_jump_address, bus.ir_load,
                       bus.exec_en, bus.halted, bus.instr_count};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Enter at the negedge of the instruction's first FETCH cycle (cycle 0). w = cycles of
    // mem_ready low; drop_at = cycle at which run is lowered (0 = never).
    task automatic run_instr(input logic [15:0] ins, input logic z, input int w,
                             input int drop_at, input bit rst_at_exec);
        logic [3:0] op;
        logic       nj;
        logic [9:0] na;
        bit         is_halt;
        int         next_cnt;
        op       = ins[15:12];
        is_halt  = (op == 4'hF);
        nj       = (op == 4'hA) || (op == 4'hB && z);
        na       = (op == 4'hA || op == 4'hB) ? ins[9:0] : 10'h000;
        next_cnt = (retired == 65535) ? 65535 : retired + 1;
        bus.instr     = ins;
        bus.zero_flag = z;
        bus.mem_ready = (w == 0);
        for (int c = 1; c <= w + 4; c++) begin
            @(negedge clk);
            bus.mem_ready = (c >= w);
            if (c == drop_at) bus.run = 1'b0;
            check_eq("strobes", 32'({bus.ir_load, bus.exec_en, bus.pc_enable}),
                     32'({c == w + 2, c == w + 3 && !is_halt, c == w + 4 && !is_halt}));
            check_eq("jump", 32'({bus.pc_jump, bus.pc_jump_address}),
                     (c >= w + 2 && !is_halt) ? 32'({nj, na}) : 32'({exp_jump, exp_addr}));
            check_eq("count", 32'(bus.instr_count),
                     (c == w + 4 && !is_halt) ? 32'(next_cnt) : 32'(retired));
            check_eq("halted", 32'(bus.halted), 32'(is_halt && c >= w + 3));
            if (rst_at_exec && c == w + 3) begin
                reset_n = 1'b0;
                #1;
                check_eq("rst_mid", 32'(all_outs), 32'd0);
                exp_jump = 1'b0;
                exp_addr = 10'h000;
                retired  = 0;
                return;
            end
        end
        if (!is_halt) begin
            exp_jump = nj;
            exp_addr = na;
            retired  = next_cnt;
        end
    endtask

    // After an instruction that dropped run: idle a few cycles, then restart.
    task automatic idle_restart(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check_eq("idle_strobes", 32'({bus.ir_load, bus.exec_en, bus.pc_enable}), 32'd0);
            check_eq("idle_jump", 32'({bus.pc_jump, bus.pc_jump_address}),
                     32'({exp_jump, exp_addr}));
        end
        bus.run = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int w;
        int drop;
        logic [15:0] ins;
`ifdef SEQ_SINGLE_STEP_EN
        bus.step = 1'b0;
`endif
        reset_n       = 1'b0;
        bus.run       = 1'b1;
        bus.mem_ready = 1'b1;
        bus.instr     = 16'h1000;
        bus.zero_flag = 1'b0;

        // Reset held with run/mem_ready active: everything stays zero.
        repeat (5) begin
            @(negedge clk);
            check_eq("reset_outs", 32'(all_outs), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);

        // Sequential instructions, then jump, branch both ways and a memory wait.
        repeat (3) run_instr(16'h1000, 1'b0, 0, 0, 1'b0);
        check_eq("seq_count", 32'(bus.instr_count), 32'd3);
        run_instr(16'hA155, 1'b0, 0, 0, 1'b0);
        run_instr(16'hB0FF, 1'b0, 0, 0, 1'b0);
        run_instr(16'hB0FF, 1'b1, 0, 0, 1'b0);
        run_instr(16'h2345, 1'b1, 5, 0, 1'b0);

        // Run dropped mid-instruction: it completes, then the sequencer idles.
        run_instr(16'hA3C7, 1'b0, 1, 2, 1'b0);
        idle_restart(3);

        // Random instruction stream (no HALT).
        for (int n = 0; n < 60; n++) begin
            ins  = 16'($urandom_range(0, 16'hEFFF));
            w    = $urandom_range(0, 3);
            drop = ($urandom_range(0, 5) == 0) ? $urandom_range(1, w + 3) : 0;
            run_instr(ins, 1'($urandom_range(0, 1)), w, drop, 1'b0);
            if (drop != 0) idle_restart($urandom_range(0, 3));
        end

        // Reset asserted while exec_en is high.
        run_instr(16'hA0AA, 1'b0, 0, 0, 1'b1);
        @(negedge clk);
        check_eq("rst_hold", 32'(all_outs), 32'd0);
        bus.run = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);

        // Two instructions then HALT: halted set, PC frozen, count stays 2.
        run_instr(16'hA011, 1'b0, 0, 0, 1'b0);
        run_instr(16'h3000, 1'b0, 0, 0, 1'b0);
        run_instr(16'hF000, 1'b0, 1, 0, 1'b0);
        repeat (6) begin
            @(negedge clk);
            check_eq("halt_flag", 32'(bus.halted), 32'd1);
            check_eq("halt_strobes", 32'({bus.ir_load, bus.exec_en, bus.pc_enable}), 32'd0);
            check_eq("halt_count", 32'(bus.instr_count), 32'd2);
        end
        reset_n = 1'b0;
        #1;
        check_eq("halt_reset", 32'(all_outs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
